// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB camera init sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sccb_pkg;

  // Table encodings and the OV7670 SCCB write ID
  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG    = 8'hFF;
  localparam logic [7:0]  OV7670_WR_ID = 8'h42;

  // Sequencer states; encodings are fixed so existing register dumps stay readable
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_GAP    = 3'd4,
    ST_DELAY  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_e;

  // One init-table word: register address in the upper byte, value in the lower
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] val;
  } tbl_entry_t;

endpackage

// File: rtl/sccb_seq_timer.sv
// Loadable down-counter with a zero flag, shared by inter-write gaps and table delays.
// Latency: load takes effect the cycle after it is asserted; zero is combinational from the count.
// Backpressure: none; the counter holds at zero until reloaded.
module sccb_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the camera init table and issues one SCCB register write per entry, with gaps, delays and NACK retries.
// Latency: req is high in the third cycle after start is sampled (FETCH, DECODE, ISSUE).
// Backpressure: req is held with stable reg_addr/wr_data until the master pulses ack; abort never cuts a write short.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int         NUM_ENTRIES = 64,
  parameter logic [7:0] DEV_ADDR    = OV7670_WR_ID,
  parameter int         GAP_CYCLES  = 1000,
  parameter int         DELAY_UNIT  = 25000,
  parameter int         RETRY_MAX   = 2,
  localparam int        IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_data,
  output logic             req,
  output logic [7:0]       dev_addr,
  output logic [7:0]       reg_addr,
  output logic [7:0]       wr_data,
  input  logic             ack,
  input  logic             nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  // Timer must hold the longest delay entry (val=255) as well as the gap count
  localparam int TMR_MAX = (255 * DELAY_UNIT > GAP_CYCLES) ? 255 * DELAY_UNIT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  // Timer runs load..0 inclusive, so a gap of N cycles loads N-1
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] UNIT     = TMR_W'(DELAY_UNIT);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);

  seq_state_e       state;
  seq_state_e       state_nxt;
  tbl_entry_t       entry;
  logic             is_end;
  logic             is_delay;
  logic [TMR_W-1:0] delay_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [RTY_W-1:0] retry;
  logic             retry_ok;
  logic             wrapped;
  logic             abort_pend;
  logic             set_done;
  logic             idx_last;
  logic [IDX_W-1:0] idx_next;

  assign entry      = tbl_entry_t'(tbl_data);
  assign is_end     = (tbl_data == END_MARK);
  assign is_delay   = (entry.addr == DELAY_REG) && !is_end;
  assign delay_load = TMR_W'(entry.val) * UNIT;
  assign retry_ok   = (retry < RTY_LIM);
  assign idx_last   = (tbl_idx == LAST_IDX);
  // Index wraps to 0 after the last entry; 'wrapped' records that the table is exhausted
  assign idx_next   = idx_last ? '0 : tbl_idx + IDX_W'(1);

  assign dev_addr = DEV_ADDR;
  assign req      = (state == ST_ISSUE);
  assign busy     = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  sccb_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and timer control; abort beats start, and in ISSUE abort only acts once ack arrives
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = GAP_LOAD;
    tmr_dec   = 1'b0;
    set_done  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start && !abort) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        state_nxt = abort ? ST_IDLE : ST_DECODE;
      end
      ST_DECODE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (is_end) begin
          state_nxt = ST_DONE;
          set_done  = 1'b1;
        end else if (is_delay) begin
          state_nxt = ST_DELAY;
          tmr_load  = 1'b1;
          tmr_val   = delay_load;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack) begin
          if (abort || abort_pend) begin
            state_nxt = ST_IDLE;
          end else if (!nack || retry_ok) begin
            state_nxt = ST_GAP;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ST_ERROR;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          state_nxt = wrapped ? ST_DONE : ST_FETCH;
          set_done  = wrapped;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DELAY: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (tmr_zero) begin
          state_nxt = idx_last ? ST_DONE : ST_FETCH;
          set_done  = idx_last;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, table index, write operands, retry bookkeeping and sticky status
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      tbl_idx    <= '0;
      err_idx    <= '0;
      reg_addr   <= '0;
      wr_data    <= '0;
      retry      <= '0;
      wrapped    <= 1'b0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (set_done) done <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start && !abort) begin
            done       <= 1'b0;
            error      <= 1'b0;
            retry      <= '0;
            tbl_idx    <= '0;
            wrapped    <= 1'b0;
            abort_pend <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (!abort && !is_end && !is_delay) begin
            reg_addr <= entry.addr;
            wr_data  <= entry.val;
          end
        end
        ST_ISSUE: begin
          if (ack) begin
            abort_pend <= 1'b0;
            // An aborted write leaves index and retry count untouched
            if (!(abort || abort_pend)) begin
              if (!nack) begin
                retry   <= '0;
                tbl_idx <= idx_next;
                if (idx_last) wrapped <= 1'b1;
              end else if (retry_ok) begin
                retry <= retry + RTY_W'(1);
              end else begin
                error   <= 1'b1;
                err_idx <= tbl_idx;
              end
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (!abort && tmr_zero) begin
            tbl_idx <= idx_next;
            if (idx_last) wrapped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: behavioural ROM and SCCB master, table-walk reference model.
// Latency: n/a.
// Backpressure: the master model acks after a random or forced number of req cycles.
module tb_sccb_init_sequencer;
  import sccb_pkg::*;

  localparam int N    = 4;
  localparam int GAP  = 4;
  localparam int DU   = 10;
  localparam int RMAX = 2;
  localparam int IW   = 2;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ack = 1'b0;
  logic          nack = 1'b0;
  logic [IW-1:0] tbl_idx;
  logic [IW-1:0] err_idx;
  logic [15:0]   tbl_data;
  logic          req, busy, done, error;
  logic [7:0]    dev_addr, reg_addr, wr_data;

  always #5 PCLK = ~PCLK;

  sccb_init_sequencer #(
    .NUM_ENTRIES (N),
    .DEV_ADDR    (8'h42),
    .GAP_CYCLES  (GAP),
    .DELAY_UNIT  (DU),
    .RETRY_MAX   (RMAX)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .start    (start),
    .abort    (abort),
    .tbl_idx  (tbl_idx),
    .tbl_data (tbl_data),
    .req      (req),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .ack      (ack),
    .nack     (nack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_idx  (err_idx)
  );

  // Registered table ROM: data valid one cycle after the address
  logic [15:0] rom [N];
  always @(posedge PCLK) tbl_data <= rom[tbl_idx];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Master model state and observations
  logic [15:0] obs_w[$];
  int          obs_g[$];
  bit          nack_q[$];
  bit          nack_plan[$];
  bit          have_prev = 0;
  bit          in_txn = 0;
  int          lat = 0, cnt = 0, low_cnt = 0;
  int          force_lat = 0;

  // Reference expectations
  logic [15:0] exp_w[$];
  int          exp_g[$];
  bit          exp_done, exp_err;
  int          exp_eidx;

  // SCCB master: ack after lat req-high cycles, plus stray ack/nack pulses that must be ignored
  initial begin
    forever begin
      @(negedge PCLK);
      ack  = 1'b0;
      nack = 1'b0;
      if (PRESET) begin
        in_txn = 0;
      end else if (req) begin
        if (!in_txn) begin
          in_txn = 1;
          cnt    = 0;
          lat    = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
          obs_w.push_back({reg_addr, wr_data});
          if (have_prev) obs_g.push_back(low_cnt);
          have_prev = 1;
          check("dev_addr", dev_addr, 8'h42);
        end
        cnt++;
        low_cnt = 0;
        if (cnt == lat) begin
          ack    = 1'b1;
          nack   = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          in_txn = 0;
        end else if ($urandom_range(0, 5) == 0) begin
          nack = 1'b1;
        end
      end else begin
        low_cnt++;
        if ($urandom_range(0, 7) == 0) begin
          ack  = 1'b1;
          nack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Walk the table as the rules describe: writes seen, req-low spacing, final status
  task automatic predict();
    int idx, k, rty, extra;
    bit first, n;
    idx = 0; k = 0; rty = 0; extra = 0; first = 1;
    exp_w.delete(); exp_g.delete();
    exp_done = 0; exp_err = 0; exp_eidx = 0;
    while (1) begin
      if (idx >= N) begin exp_done = 1; break; end
      if (rom[idx] == 16'hFFFF) begin exp_done = 1; break; end
      if (rom[idx][15:8] == 8'hFF) begin
        // fetch + decode of the delay entry, then val*DU+1 cycles counting down
        extra += 3 + int'(rom[idx][7:0]) * DU;
        idx++;
        continue;
      end
      exp_w.push_back(rom[idx]);
      if (!first) exp_g.push_back(GAP + 2 + extra);
      first = 0;
      extra = 0;
      n = (k < nack_plan.size()) ? nack_plan[k] : 1'b0;
      k++;
      if (!n) begin rty = 0; idx++; end
      else if (rty < RMAX) rty++;
      else begin exp_err = 1; exp_eidx = idx; break; end
    end
  endtask

  task automatic pulse_start();
    @(negedge PCLK);
    start = 1'b1;
    @(posedge PCLK);
    #1 start = 1'b0;
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_g.delete(); have_prev = 0;
  endtask

  task automatic run_seq(input string tag, input bit mid_start);
    int t;
    predict();
    nack_q = nack_plan;
    clear_obs();
    pulse_start();
    @(negedge PCLK);
    check({tag, "/busy_after_start"}, busy, 1'b1);
    check({tag, "/done_cleared"}, done, 1'b0);
    check({tag, "/error_cleared"}, error, 1'b0);
    if (rom[0][15:8] != 8'hFF) begin
      @(negedge PCLK); check({tag, "/req_low_decode"}, req, 1'b0);
      @(negedge PCLK); check({tag, "/req_high_3rd_cycle"}, req, 1'b1);
    end
    if (mid_start) begin
      repeat ($urandom_range(1, 10)) @(negedge PCLK);
      if (busy) begin
        start = 1'b1;
        @(posedge PCLK);
        #1 start = 1'b0;
      end
    end
    t = 0;
    while (busy && t < 3000) begin @(negedge PCLK); t++; end
    check({tag, "/finished"}, busy, 1'b0);
    repeat (2) @(negedge PCLK);
    check({tag, "/n_writes"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      check({tag, "/write"}, obs_w[i], exp_w[i]);
    check({tag, "/n_gaps"}, obs_g.size(), exp_g.size());
    for (int i = 0; i < obs_g.size() && i < exp_g.size(); i++)
      check({tag, "/gap"}, obs_g[i], exp_g[i]);
    check({tag, "/done"}, done, exp_done);
    check({tag, "/error"}, error, exp_err);
    if (exp_err) check({tag, "/err_idx"}, err_idx, exp_eidx);
    check({tag, "/req_idle"}, req, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, h;
    for (int i = 0; i < N; i++) rom[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst/req", req, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/error", error, 1'b0);
    check("rst/tbl_idx", tbl_idx, 0);
    check("rst/err_idx", err_idx, 0);
    check("rst/reg_wr", {reg_addr, wr_data}, 16'h0000);
    PRESET = 1'b0;

    // Two writes around a one-unit delay
    rom = '{16'h1280, 16'hFF01, 16'h1101, 16'hFFFF};
    nack_plan.delete();
    force_lat = 5;
    run_seq("basic", 0);
    force_lat = 0;

    // Two NACKs then ACK on entry 0
    rom = '{16'h1280, 16'h3456, 16'hFFFF, 16'h0000};
    nack_plan = '{1, 1, 0};
    run_seq("retry", 0);

    // Entry 2 NACKed three times, then a clean restart
    rom = '{16'h1280, 16'h1101, 16'h2233, 16'hFFFF};
    nack_plan = '{0, 0, 1, 1, 1};
    run_seq("err", 0);
    nack_plan.delete();
    run_seq("restart", 0);

    // Full table with no end marker
    rom = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
    run_seq("full", 0);

    // abort while ISSUE waits 20 cycles for ack
    rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
    nack_q.delete();
    force_lat = 20;
    clear_obs();
    pulse_start();
    t = 0;
    while (!req && t < 20) begin @(negedge PCLK); t++; end
    check("abort_issue/req_up", req, 1'b1);
    repeat (3) @(negedge PCLK);
    abort = 1'b1;
    @(posedge PCLK);
    #1 abort = 1'b0;
    @(negedge PCLK);
    check("abort_issue/req_hold", req, 1'b1);
    h = 5;
    t = 0;
    while (req && t < 100) begin @(negedge PCLK); if (req) h++; t++; end
    check("abort_issue/req_high_cycles", h, 20);
    check("abort_issue/idle", busy, 1'b0);
    check("abort_issue/idx_frozen", tbl_idx, 0);
    check("abort_issue/done", done, 1'b0);
    repeat (8) @(negedge PCLK);
    check("abort_issue/stays_idle", busy, 1'b0);
    check("abort_issue/one_write", obs_w.size(), 1);
    force_lat = 0;

    // abort in DELAY
    rom = '{16'hFF05, 16'h1280, 16'hFFFF, 16'h0000};
    clear_obs();
    pulse_start();
    repeat (4) @(negedge PCLK);
    check("abort_delay/busy", busy, 1'b1);
    abort = 1'b1;
    @(posedge PCLK);
    #1 abort = 1'b0;
    check("abort_delay/idle_next", busy, 1'b0);
    check("abort_delay/idx", tbl_idx, 0);
    repeat (10) @(negedge PCLK);
    check("abort_delay/no_write", obs_w.size(), 0);

    // start and abort together from IDLE
    @(negedge PCLK);
    start = 1'b1; abort = 1'b1;
    @(posedge PCLK);
    #1 start = 1'b0; abort = 1'b0;
    check("start_abort/idle", busy, 1'b0);
    repeat (5) @(negedge PCLK);
    check("start_abort/still_idle", busy, 1'b0);
    check("start_abort/no_write", obs_w.size(), 0);

    // Randomised tables, NACK patterns and stray start pulses
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0 && i > 0)  rom[i] = 16'hFFFF;
        else if (sel == 1)      rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
        else                    rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
      end
      nack_plan.delete();
      for (int k = 0; k < 8; k++) nack_plan.push_back($urandom_range(0, 3) == 0);
      run_seq("rand", 1);
    end

    // PRESET in the middle of ISSUE
    rom = '{16'h5A6B, 16'hFFFF, 16'h0000, 16'h0000};
    nack_q.delete();
    force_lat = 1000;
    clear_obs();
    pulse_start();
    t = 0;
    while (!req && t < 20) begin @(negedge PCLK); t++; end
    check("preset/req_up", req, 1'b1);
    repeat (2) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    check("preset/req", req, 1'b0);
    check("preset/busy", busy, 1'b0);
    check("preset/done", done, 1'b0);
    check("preset/error", error, 1'b0);
    check("preset/tbl_idx", tbl_idx, 0);
    check("preset/reg_wr", {reg_addr, wr_data}, 16'h0000);
    @(negedge PCLK);
    PRESET = 1'b0;
    force_lat = 0;

    rom = '{16'h0102, 16'hFF00, 16'h0304, 16'hFFFF};
    nack_plan = '{0, 1, 0};
    run_seq("after_preset", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
